// File: rtl/core_lsu_refill.sv
// Data-cache line refill: victim pick, dirty write-back, burst line read, RAM/tag update, critical word return.
// Latency: clean miss with a zero-wait bus gives done 7 cycles after req; a dirty victim adds LINE_WORDS+1 load cycles plus write-back.
// Backpressure: address and write-data channels hold until ready; read data and write response are always accepted.
module core_lsu_refill #(
  parameter  int WAY_CNT    = 2,
  parameter  int LINE_WORDS = 4,
  parameter  int IDX_LEN    = 12,
  localparam int WAY_W      = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1,
  localparam int WORD_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int OFF_W      = WORD_W + 2,
  localparam int SET_W      = IDX_LEN - OFF_W,
  localparam int PTAG_W     = 32 - IDX_LEN,
  localparam int TAG_W      = PTAG_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     refill_req_i,
  input  logic [31:0]              refill_addr_i,
  input  logic [WAY_CNT*TAG_W-1:0] tag_rdata_i,
  output logic                     dram_take_over_o,
  output logic [IDX_LEN-3:0]       data_raddr_o,
  input  logic [WAY_CNT*32-1:0]    data_rdata_i,
  output logic [WAY_CNT*4-1:0]     data_we_o,
  output logic [IDX_LEN-3:0]       data_waddr_o,
  output logic [31:0]              data_wdata_o,
  output logic [WAY_CNT-1:0]       tag_we_o,
  output logic [SET_W-1:0]         tag_waddr_o,
  output logic [TAG_W-1:0]         tag_wdata_o,
  output logic                     rd_req_o,
  output logic [31:0]              rd_addr_o,
  output logic [7:0]               rd_len_o,
  input  logic                     rd_ready_i,
  input  logic                     rvalid_i,
  input  logic [31:0]              rdata_i,
  input  logic                     rlast_i,
  output logic                     wr_req_o,
  output logic [31:0]              wr_addr_o,
  output logic [7:0]               wr_len_o,
  input  logic                     wr_ready_i,
  output logic                     wvalid_o,
  output logic [31:0]              wdata_o,
  output logic                     wlast_o,
  input  logic                     wready_i,
  input  logic                     bvalid_i,
  output logic                     read_ready_o,
  output logic [31:0]              rdata_o,
  output logic                     done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WB_LOAD, S_WB_ADDR, S_WB_DATA, S_WB_RESP,
    S_RD_ADDR, S_RD_DATA, S_TAG, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W:0]   cnt_q, cnt_d;          // load step / write beat / read beat
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [WAY_W-1:0]  rr_q, rr_d;
  logic [31:2]       addr_q, addr_d;
  logic [PTAG_W-1:0] wb_ptag_q, wb_ptag_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              read_ready_q, read_ready_d;
  logic [31:0]       wb_buf_q [LINE_WORDS];

  logic              free_found;
  logic [WAY_W-1:0]  free_way, pick_way;
  logic [TAG_W-1:0]  pick_tag;
  logic [SET_W-1:0]  set_idx;
  logic [WORD_W-1:0] crit_word, cnt_word, load_slot;
  logic [31:0]       victim_rdata;
  logic              unused_addr_bits;

  assign set_idx          = addr_q[IDX_LEN-1:OFF_W];
  assign crit_word        = addr_q[OFF_W-1:2];
  assign cnt_word         = cnt_q[WORD_W-1:0];
  // RAM data lags the address by one cycle, so step k captures word k-1.
  assign load_slot        = cnt_word - WORD_W'(1);
  assign victim_rdata     = data_rdata_i[32*int'(victim_q) +: 32];
  assign read_ready_o     = read_ready_q;
  assign rdata_o          = rdata_q;
  assign unused_addr_bits = ^refill_addr_i[1:0];

  // Victim choice: lowest invalid way, otherwise the round-robin way.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (!free_found && !tag_rdata_i[w*TAG_W + TAG_W-1]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    pick_way = free_found ? free_way : rr_q;
    pick_tag = tag_rdata_i[int'(pick_way)*TAG_W +: TAG_W];
  end

  // State register and per-refill context, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      victim_q     <= '0;
      rr_q         <= '0;
      addr_q       <= '0;
      wb_ptag_q    <= '0;
      rdata_q      <= '0;
      read_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      rr_q         <= rr_d;
      addr_q       <= addr_d;
      wb_ptag_q    <= wb_ptag_d;
      rdata_q      <= rdata_d;
      read_ready_q <= read_ready_d;
    end
  end

  // Victim line buffer filled during the write-back load; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_WB_LOAD && cnt_q != '0) begin
      wb_buf_q[load_slot] <= victim_rdata;
    end
  end

  // Next-state and output decode; every output idles at zero.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    victim_d         = victim_q;
    rr_d             = rr_q;
    addr_d           = addr_q;
    wb_ptag_d        = wb_ptag_q;
    rdata_d          = rdata_q;
    read_ready_d     = 1'b0;
    dram_take_over_o = 1'b0;
    data_raddr_o     = '0;
    data_we_o        = '0;
    data_waddr_o     = '0;
    data_wdata_o     = '0;
    tag_we_o         = '0;
    tag_waddr_o      = '0;
    tag_wdata_o      = '0;
    rd_req_o         = 1'b0;
    rd_addr_o        = '0;
    rd_len_o         = '0;
    wr_req_o         = 1'b0;
    wr_addr_o        = '0;
    wr_len_o         = '0;
    wvalid_o         = 1'b0;
    wdata_o          = '0;
    wlast_o          = 1'b0;
    done_o           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (refill_req_i) begin
          addr_d    = refill_addr_i[31:2];
          victim_d  = pick_way;
          wb_ptag_d = pick_tag[PTAG_W-1:0];
          cnt_d     = '0;
          state_d   = (pick_tag[TAG_W-1] && pick_tag[TAG_W-2]) ? S_WB_LOAD : S_RD_ADDR;
        end
      end
      S_WB_LOAD: begin
        dram_take_over_o = 1'b1;
        data_raddr_o     = {set_idx, cnt_word};
        if (cnt_q == (WORD_W+1)'(LINE_WORDS)) begin
          cnt_d   = '0;
          state_d = S_WB_ADDR;
        end else begin
          cnt_d = cnt_q + (WORD_W+1)'(1);
        end
      end
      S_WB_ADDR: begin
        wr_req_o  = 1'b1;
        wr_addr_o = {wb_ptag_q, set_idx, {OFF_W{1'b0}}};
        wr_len_o  = 8'(LINE_WORDS-1);
        if (wr_ready_i) begin
          cnt_d   = '0;
          state_d = S_WB_DATA;
        end
      end
      S_WB_DATA: begin
        wvalid_o = 1'b1;
        wdata_o  = wb_buf_q[cnt_word];
        wlast_o  = (cnt_word == WORD_W'(LINE_WORDS-1));
        if (wready_i) begin
          cnt_d = cnt_q + (WORD_W+1)'(1);
          if (wlast_o) state_d = S_WB_RESP;
        end
      end
      S_WB_RESP: begin
        if (bvalid_i) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        rd_req_o  = 1'b1;
        rd_addr_o = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
        rd_len_o  = 8'(LINE_WORDS-1);
        if (rd_ready_i) begin
          cnt_d   = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid_i) begin
          data_we_o[4*int'(victim_q) +: 4] = 4'hf;
          data_waddr_o = {set_idx, cnt_word};
          data_wdata_o = rdata_i;
          if (cnt_word == crit_word) begin
            rdata_d      = rdata_i;
            read_ready_d = 1'b1;
          end
          cnt_d = cnt_q + (WORD_W+1)'(1);
          if (rlast_i) state_d = S_TAG;
        end
      end
      S_TAG: begin
        tag_we_o[victim_q] = 1'b1;
        tag_waddr_o        = set_idx;
        tag_wdata_o        = {1'b1, 1'b0, addr_q[31:IDX_LEN]};
        state_d            = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        rr_d    = rr_q + WAY_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_lsu_refill.sv
// Randomized bench for core_lsu_refill: TB-side RAM, bus slave and line-level reference model.
module tb_core_lsu_refill;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        refill_req_i;
  logic [31:0] refill_addr_i;
  logic [43:0] tag_rdata_i;
  logic        dram_take_over_o;
  logic [9:0]  data_raddr_o;
  logic [63:0] data_rdata_i;
  logic [7:0]  data_we_o;
  logic [9:0]  data_waddr_o;
  logic [31:0] data_wdata_o;
  logic [1:0]  tag_we_o;
  logic [7:0]  tag_waddr_o;
  logic [21:0] tag_wdata_o;
  logic        rd_req_o, rd_ready_i, rvalid_i, rlast_i;
  logic [31:0] rd_addr_o, rdata_i;
  logic [7:0]  rd_len_o;
  logic        wr_req_o, wr_ready_i, wvalid_o, wlast_o, wready_i, bvalid_i;
  logic [31:0] wr_addr_o, wdata_o;
  logic [7:0]  wr_len_o;
  logic        read_ready_o, done_o;
  logic [31:0] rdata_o;

  core_lsu_refill #(.WAY_CNT(2), .LINE_WORDS(4), .IDX_LEN(12)) dut (
    .clk(clk), .rst(rst), .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
    .tag_rdata_i(tag_rdata_i), .dram_take_over_o(dram_take_over_o), .data_raddr_o(data_raddr_o),
    .data_rdata_i(data_rdata_i), .data_we_o(data_we_o), .data_waddr_o(data_waddr_o),
    .data_wdata_o(data_wdata_o), .tag_we_o(tag_we_o), .tag_waddr_o(tag_waddr_o),
    .tag_wdata_o(tag_wdata_o), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .rd_ready_i(rd_ready_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rlast_i(rlast_i),
    .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_len_o(wr_len_o), .wr_ready_i(wr_ready_i),
    .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wlast_o(wlast_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .read_ready_o(read_ready_o), .rdata_o(rdata_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // RAM seen by the DUT and the RAM the model says it should hold.
  logic [31:0] ram     [WAYS][1024];
  logic [31:0] exp_ram [WAYS][1024];

  bit          req_on, rst_on, stall_on;
  logic [31:0] cur_addr;
  logic [43:0] cur_tags;

  bit          rd_act, b_pend;
  int          rd_beat;
  logic [31:0] rd_base;
  logic [9:0]  raddr_prev;

  int          rr_m;
  int          exp_victim;
  bit          exp_dirty;
  logic [7:0]  exp_set;
  logic [31:0] exp_wb_addr, exp_crit;
  logic [21:0] exp_tag;
  logic [31:0] exp_wb [LW];
  int n_rr, n_tag, n_we, n_take, n_wr, n_wreq, n_beats, n_done;
  int rdreq_cyc, wbdone_cyc, rr_cyc, tag_cyc, done_cyc, victim_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [21:0] mk_tag(input bit v, input bit d, input logic [19:0] p);
    return {v, d, p};
  endfunction

  // One clock: drive inputs at negedge, observe settled outputs 1ns later.
  task automatic step();
    @(negedge clk);
    rst           = rst_on;
    refill_req_i  = req_on;
    refill_addr_i = cur_addr;
    tag_rdata_i   = cur_tags;
    data_rdata_i  = {ram[1][raddr_prev], ram[0][raddr_prev]};
    rd_ready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rlast_i = 1'b0;
    wr_ready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    if (!rst_on) begin
      if (rd_req_o) rd_ready_i = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_act && (!stall_on || $urandom_range(0, 2) != 0)) begin
        rvalid_i = 1'b1;
        rdata_i  = mem_word(rd_base + 32'(rd_beat * 4));
        rlast_i  = (rd_beat == LW - 1);
      end
      if (wr_req_o) wr_ready_i = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      wready_i = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_pend) bvalid_i = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    raddr_prev = data_raddr_o;
    if (rst_on) begin
      rd_act = 1'b0;
      b_pend = 1'b0;
    end
    if (dram_take_over_o) n_take++;
    if (rvalid_i) begin
      n_beats++;
      rd_beat++;
      if (rlast_i) rd_act = 1'b0;
    end
    if (rd_req_o && rdreq_cyc < 0) rdreq_cyc = cyc;
    if (rd_req_o && rd_ready_i) begin
      chk("rd_addr", rd_addr_o, {cur_addr[31:4], 4'h0});
      chk("rd_len", rd_len_o, 3);
      rd_act  = 1'b1;
      rd_beat = 0;
      rd_base = rd_addr_o;
    end
    if (data_we_o != '0) begin
      chk("we_mask", data_we_o, 8'hf << (4 * exp_victim));
      chk("we_rvalid", rvalid_i, 1);
      chk("we_addr", data_waddr_o, {exp_set, 2'(n_we)});
      chk("we_data", data_wdata_o, mem_word({cur_addr[31:4], 2'(n_we), 2'b00}));
      for (int w = 0; w < WAYS; w++)
        for (int b = 0; b < 4; b++)
          if (data_we_o[w*4 + b]) ram[w][data_waddr_o][b*8 +: 8] = data_wdata_o[b*8 +: 8];
      n_we++;
    end
    if (wr_req_o) n_wreq++;
    if (wr_req_o && wr_ready_i) begin
      chk("wr_addr", wr_addr_o, exp_wb_addr);
      chk("wr_len", wr_len_o, 3);
    end
    if (bvalid_i) begin
      b_pend     = 1'b0;
      wbdone_cyc = cyc;
    end
    if (wvalid_o && wready_i) begin
      if (n_wr < LW) chk("wdata", wdata_o, exp_wb[n_wr]);
      else chk("wr_extra_beat", 1, 0);
      chk("wlast", wlast_o, (n_wr == LW - 1));
      n_wr++;
      if (wlast_o) b_pend = 1'b1;
    end
    if (read_ready_o) begin
      chk("crit_word", rdata_o, exp_crit);
      n_rr++;
      rr_cyc = cyc;
    end
    if (tag_we_o != '0) begin
      chk("tag_we", tag_we_o, 2'b01 << exp_victim);
      chk("tag_waddr", tag_waddr_o, exp_set);
      chk("tag_wdata", tag_wdata_o, exp_tag);
      victim_seen = tag_we_o[1] ? 1 : 0;
      n_tag++;
      tag_cyc = cyc;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  // Run one refill against the model; abort_beats >= 0 stops after that many read beats.
  task automatic do_refill(input logic [31:0] addr, input logic [43:0] tags,
                           input bit stall, input int abort_beats);
    int start;
    int crit;
    bit found;
    logic [21:0] vt;
    found = 1'b0;
    exp_victim = rr_m;
    for (int w = 0; w < WAYS; w++)
      if (!found && !tags[w*22 + 21]) begin
        exp_victim = w;
        found = 1'b1;
      end
    vt          = tags[exp_victim*22 +: 22];
    exp_dirty   = vt[21] & vt[20];
    exp_set     = addr[11:4];
    exp_wb_addr = {vt[19:0], exp_set, 4'h0};
    for (int k = 0; k < LW; k++) exp_wb[k] = exp_ram[exp_victim][{exp_set, 2'(k)}];
    exp_crit    = mem_word({addr[31:2], 2'b00});
    exp_tag     = {2'b10, addr[31:12]};
    crit        = int'(addr[3:2]);
    n_rr = 0; n_tag = 0; n_we = 0; n_take = 0; n_wr = 0; n_wreq = 0; n_beats = 0; n_done = 0;
    rdreq_cyc = -1; wbdone_cyc = -1; rr_cyc = -1; tag_cyc = -1; done_cyc = -1; victim_seen = -1;
    cur_addr = addr; cur_tags = tags; stall_on = stall; req_on = 1'b1;
    start = cyc;
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      step();
      if (abort_beats >= 0 && n_beats >= abort_beats) break;
    end
    req_on = 1'b0;
    if (abort_beats >= 0) return;
    if (n_done == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("n_read_ready", n_rr, 1);
    chk("n_tag_we", n_tag, 1);
    chk("n_ram_writes", n_we, LW);
    chk("take_over_cycles", n_take, exp_dirty ? LW + 1 : 0);
    chk("wb_beats", n_wr, exp_dirty ? LW : 0);
    if (exp_dirty) chk("wb_before_rd", (wbdone_cyc >= 0 && wbdone_cyc < rdreq_cyc), 1);
    else chk("no_wr_req_clean", n_wreq, 0);
    if (!stall) begin
      chk("done_latency", done_cyc - start, exp_dirty ? 18 : 7);
      chk("crit_latency", rr_cyc - start, (exp_dirty ? 11 : 0) + 3 + crit);
    end
    for (int k = 0; k < LW; k++) begin
      exp_ram[exp_victim][{exp_set, 2'(k)}] = mem_word({addr[31:4], 2'(k), 2'b00});
      chk("line_word", ram[exp_victim][{exp_set, 2'(k)}], exp_ram[exp_victim][{exp_set, 2'(k)}]);
    end
    rr_m = (rr_m + 1) % WAYS;
    step();
  endtask

  initial begin
    logic [43:0] tags;
    logic [31:0] a, w;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < WAYS; k++) begin
        w = $urandom;
        ram[k][i] = w;
        exp_ram[k][i] = w;
      end
    req_on = 0; rst_on = 1; stall_on = 0; cur_addr = '0; cur_tags = '0;
    rd_act = 0; b_pend = 0; rd_beat = 0; rd_base = '0; raddr_prev = '0; rr_m = 0;
    exp_victim = 0; exp_set = '0; exp_wb_addr = '0; exp_crit = '0; exp_tag = '0;

    // Reset: every output quiet.
    repeat (3) step();
    chk("reset_outputs", |{dram_take_over_o, data_raddr_o, data_we_o, data_waddr_o, data_wdata_o,
                           tag_we_o, tag_waddr_o, tag_wdata_o, rd_req_o, rd_addr_o, rd_len_o,
                           wr_req_o, wr_addr_o, wr_len_o, wvalid_o, wdata_o, wlast_o,
                           read_ready_o, done_o}, 0);
    chk("reset_rdata", rdata_o, 0);
    rst_on = 0;
    step();

    // All ways valid and clean: round-robin picks way 0 then way 1.
    tags = {mk_tag(1, 0, 20'h11111), mk_tag(1, 0, 20'h22222)};
    do_refill(32'h0000_4020, tags, 0, -1);
    chk("rr_first_victim", victim_seen, 0);
    do_refill(32'h0000_5030, tags, 0, -1);
    chk("rr_second_victim", victim_seen, 1);

    // Clean miss into invalid way 0.
    tags = {mk_tag(1, 1, 20'h33333), mk_tag(0, 0, 20'h00000)};
    do_refill(32'h1234_5678, tags, 0, -1);
    chk("clean_victim", victim_seen, 0);

    // Dirty victim ptag 0xABCDE at index 0x10.
    tags = (rr_m == 0) ? {mk_tag(1, 0, 20'h44444), mk_tag(1, 1, 20'hABCDE)}
                       : {mk_tag(1, 1, 20'hABCDE), mk_tag(1, 0, 20'h44444)};
    do_refill(32'h7654_3104, tags, 0, -1);
    chk("dirty_wb_addr", exp_wb_addr, 32'hABCD_E100);

    // Critical word in the last slot: read_ready lines up with the tag write.
    tags = {mk_tag(1, 0, 20'h55555), mk_tag(0, 0, 20'h0)};
    do_refill(32'h0000_1ABC, tags, 0, -1);
    chk("crit3_with_tag", rr_cyc, tag_cyc);

    // Reset during the read burst, after beat 1.
    tags = {mk_tag(1, 0, 20'h66666), mk_tag(0, 0, 20'h0)};
    do_refill(32'h0BAD_F00C, tags, 0, 2);
    rst_on = 1;
    step();
    rst_on = 0;
    step();
    chk("midrst_outputs", |{dram_take_over_o, data_raddr_o, data_we_o, data_waddr_o, data_wdata_o,
                            tag_we_o, tag_waddr_o, tag_wdata_o, rd_req_o, rd_addr_o, rd_len_o,
                            wr_req_o, wr_addr_o, wr_len_o, wvalid_o, wdata_o, wlast_o,
                            read_ready_o, done_o}, 0);
    chk("midrst_rdata", rdata_o, 0);
    for (int k = 0; k < 2; k++)
      exp_ram[0][{8'h00, 2'(k)}] = mem_word({28'h0BADF00, 2'(k), 2'b00});
    rr_m = 0;
    do_refill(32'h0BAD_F00C, tags, 0, -1);

    // Same dirty/clean mix with random stalls on every handshake.
    tags = {mk_tag(1, 1, 20'h77777), mk_tag(1, 1, 20'h88888)};
    do_refill(32'h1234_5678, tags, 1, -1);
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      tags = {mk_tag(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 20'($urandom)),
              mk_tag(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 20'($urandom))};
      do_refill(a, tags, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
